// File: rtl/dff_pattern_driver_if.sv
// rtl/dff_pattern_driver_if.sv - D/Q/Qn link between the pattern driver and the flop under test
interface dff_pattern_driver_if;
    logic D;
    logic Q;
    logic Qn;

    modport master (
        output D,
        input  Q,
        input  Qn
    );

    modport slave (
        input  D,
        output Q,
        output Qn
    );
endinterface

// File: rtl/dff_pattern_driver.sv
// rtl/dff_pattern_driver.sv - LFSR stimulus source and Q/Qn response checker for a single-bit flop
module dff_pattern_driver #(
    parameter int         N_VECTORS = 64,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    dff_pattern_driver_if.master flop,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     first_err_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0]       SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VECTORS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    state_t           state_next;
    logic [7:0]       lfsr;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] chk_idx;
    logic             d_reg;
    logic             d_prev;
    logic             chk_valid;
    logic             accept;
    logic             last_vec;
    logic             vec_err;
    logic [CNT_W-1:0] err_next;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    assign flop.D   = d_reg;
    assign last_vec = (vec_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DRIVE;
                    accept     = 1'b1;
                end
            end
            DRIVE: begin
                busy = 1'b1;
                if (last_vec) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A vector is checked one cycle after it left D; a Q or Qn fault counts once.
    always_comb begin
        vec_err  = chk_valid && ((flop.Q != d_prev) || (flop.Qn == flop.Q));
        err_next = err_count;
        if (vec_err && (err_count != CNT_MAX)) begin
            err_next = err_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr          <= SEED_EFF;
            d_reg         <= 1'b0;
            d_prev        <= 1'b0;
            chk_valid     <= 1'b0;
            chk_idx       <= '0;
            vec_cnt       <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            pass          <= 1'b0;
        end else begin
            d_prev    <= d_reg;
            chk_valid <= (state == DRIVE);
            chk_idx   <= vec_cnt;

            err_count <= err_next;
            if (vec_err && (err_count == '0)) begin
                first_err_idx <= chk_idx;
            end

            if (state == DRAIN) begin
                pass <= (err_next == '0);
            end

            if (accept) begin
                lfsr          <= lfsr_step(SEED_EFF);
                d_reg         <= SEED_EFF[0];
                vec_cnt       <= '0;
                err_count     <= '0;
                first_err_idx <= '0;
                pass          <= 1'b0;
            end else if (state == DRIVE) begin
                lfsr <= lfsr_step(lfsr);
                if (last_vec) begin
                    d_reg <= 1'b0;
                end else begin
                    d_reg   <= lfsr[0];
                    vec_cnt <= vec_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dff_pattern_driver.sv
// tb/tb_dff_pattern_driver.sv - randomized fault-injection bench for dff_pattern_driver
module tb_dff_pattern_driver;

    localparam int N_A  = 64;
    localparam int N_B  = 16;
    localparam int N_C  = 15;
    localparam int CW_C = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst, a_start, a_busy, a_done, a_pass;
    logic [7:0] a_err, a_first;
    logic bc_rst, b_start, b_busy, b_done, b_pass;
    logic [7:0] b_err, b_first;
    logic c_start, c_busy, c_done, c_pass;
    logic [CW_C-1:0] c_err, c_first;

    dff_pattern_driver_if ifa ();
    dff_pattern_driver_if ifb ();
    dff_pattern_driver_if ifc ();

    dff_pattern_driver #(.N_VECTORS(N_A), .LFSR_SEED(8'hA5), .CNT_W(8)) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .flop(ifa),
        .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_count(a_err), .first_err_idx(a_first)
    );

    dff_pattern_driver #(.N_VECTORS(N_B), .LFSR_SEED(8'hA5), .CNT_W(8)) dut_b (
        .clk(clk), .rst(bc_rst), .start(b_start), .flop(ifb),
        .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_count(b_err), .first_err_idx(b_first)
    );

    dff_pattern_driver #(.N_VECTORS(N_C), .LFSR_SEED(8'hA5), .CNT_W(CW_C)) dut_c (
        .clk(clk), .rst(bc_rst), .start(c_start), .flop(ifc),
        .busy(c_busy), .done(c_done), .pass(c_pass),
        .err_count(c_err), .first_err_idx(c_first)
    );

    // Behavioural flops: A has injectable faults, B has Qn tied to Q, C has Q stuck inverted.
    logic a_flop, b_flop, c_flop;
    logic a_flip, a_qnbad;
    always @(posedge clk) begin
        a_flop <= ifa.D;
        b_flop <= ifb.D;
        c_flop <= ifc.D;
    end
    assign ifa.Q  = a_flop ^ a_flip;
    assign ifa.Qn = ~ifa.Q ^ a_qnbad;
    assign ifb.Q  = b_flop;
    assign ifb.Qn = b_flop;
    assign ifc.Q  = ~c_flop;
    assign ifc.Qn = c_flop;

    int vectors = 0;
    int miscompares = 0;

    bit pat [N_A];
    bit flip_q [N_A];
    bit qn_bad [N_A];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic build_pattern();
        logic [7:0] l;
        l = 8'hA5;
        for (int i = 0; i < N_A; i++) begin
            pat[i] = l[0];
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N_A; i++) begin
            flip_q[i] = 1'b0;
            qn_bad[i] = 1'b0;
        end
    endtask

    // One full run on A; restart_cyc>0 pulses start in that cycle, which must be ignored.
    task automatic run_a(input string tag, input int restart_cyc);
        int exp_err, exp_first, busy_cycles, vi;
        bit seen;
        exp_err = 0;
        exp_first = 0;
        seen = 0;
        for (int i = 0; i < N_A; i++) begin
            if (flip_q[i] || qn_bad[i]) begin
                if (!seen) exp_first = i;
                seen = 1;
                exp_err++;
            end
        end
        if (exp_err > 255) exp_err = 255;

        busy_cycles = 0;
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= N_A + 3; cyc++) begin
            a_start = (cyc == restart_cyc);
            vi = cyc - 2;
            a_flip  = (vi >= 0 && vi < N_A) ? flip_q[vi] : 1'b0;
            a_qnbad = (vi >= 0 && vi < N_A) ? qn_bad[vi] : 1'b0;
            @(negedge clk);
            check_eq({tag, "_d"}, 32'(ifa.D), (cyc <= N_A) ? 32'(pat[cyc-1]) : 32'd0);
            check_eq({tag, "_done"}, 32'(a_done), 32'(cyc == N_A + 2));
            if (a_busy) busy_cycles++;
            if (cyc == N_A + 2) begin
                check_eq({tag, "_err"}, 32'(a_err), 32'(exp_err));
                check_eq({tag, "_first"}, 32'(a_first), 32'(exp_first));
                check_eq({tag, "_pass"}, 32'(a_pass), 32'(exp_err == 0));
            end
            @(posedge clk);
            #1;
        end
        a_start = 1'b0;
        a_flip = 1'b0;
        a_qnbad = 1'b0;
        check_eq({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(N_A + 1));
        check_eq({tag, "_pass_held"}, 32'(a_pass), 32'(exp_err == 0));
    endtask

    initial begin
        int cyc;
        build_pattern();
        clear_faults();
        a_flip = 1'b0;
        a_qnbad = 1'b0;

        // Reset held with start high: nothing may start.
        a_rst = 1'b1; bc_rst = 1'b1;
        a_start = 1'b1; b_start = 1'b1; c_start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_d", 32'(ifa.D), 0);
        check_eq("rst_busy", 32'(a_busy), 0);
        check_eq("rst_done", 32'(a_done), 0);
        check_eq("rst_pass", 32'(a_pass), 0);
        check_eq("rst_err", 32'(a_err), 0);
        check_eq("rst_first", 32'(a_first), 0);
        @(negedge clk);
        a_rst = 1'b0; bc_rst = 1'b0;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_no_run", 32'(a_busy), 0);

        run_a("good", 0);

        clear_faults();
        flip_q[5] = 1'b1;
        run_a("fault5", 0);

        clear_faults();
        run_a("restart_ignored", 20);

        for (int r = 0; r < 6; r++) begin
            clear_faults();
            if (r != 0) begin
                for (int i = 0; i < N_A; i++) begin
                    flip_q[i] = ($urandom_range(0, 15) == 0);
                    qn_bad[i] = ($urandom_range(0, 15) == 0);
                end
            end
            run_a($sformatf("rand%0d", r), (r == 3) ? int'($urandom_range(2, N_A)) : 0);
        end

        // Reset while vector 10 is on D, after one error has been recorded.
        clear_faults();
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        for (cyc = 1; cyc < 11; cyc++) begin
            a_flip = (cyc == 4);
            @(posedge clk);
            #1;
        end
        a_flip = 1'b0;
        @(negedge clk);
        check_eq("mid_d_v10", 32'(ifa.D), 32'(pat[10]));
        check_eq("mid_err", 32'(a_err), 1);
        check_eq("mid_first", 32'(a_first), 2);
        a_rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_d", 32'(ifa.D), 0);
        check_eq("midrst_busy", 32'(a_busy), 0);
        check_eq("midrst_done", 32'(a_done), 0);
        check_eq("midrst_pass", 32'(a_pass), 0);
        check_eq("midrst_err", 32'(a_err), 0);
        check_eq("midrst_first", 32'(a_first), 0);
        @(negedge clk);
        a_rst = 1'b0;
        run_a("after_rst", 0);

        // B: Qn tied to Q, every vector fails.
        @(negedge clk);
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        cyc = 1;
        while (!b_done && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("qn_tied_done_cyc", 32'(cyc), 32'(N_B + 2));
        check_eq("qn_tied_err", 32'(b_err), 32'(N_B));
        check_eq("qn_tied_first", 32'(b_first), 0);
        check_eq("qn_tied_pass", 32'(b_pass), 0);

        // C: Q stuck inverted with a 4-bit counter, twice.
        for (int run = 0; run < 2; run++) begin
            @(negedge clk);
            c_start = 1'b1;
            @(posedge clk);
            #1;
            c_start = 1'b0;
            cyc = 1;
            while (!c_done && cyc < 60) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check_eq("sat_done_cyc", 32'(cyc), 32'(N_C + 2));
            check_eq("sat_err", 32'(c_err), 32'(N_C));
            check_eq("sat_first", 32'(c_first), 0);
            check_eq("sat_pass", 32'(c_pass), 0);
            repeat (3) @(posedge clk);
            #1;
            check_eq("sat_err_hold", 32'(c_err), 32'(N_C));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
